// File: rtl/wolfram_ca_engine_pkg.sv
// Shared types and constants for the 1-D elementary cellular automaton engine.
package wolfram_ca_engine_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ca_state_t;

  localparam int RULE_IDX_W = 3;

endpackage

// File: rtl/wolfram_ca_engine_ca_rule_cell.sv
// One-cell rule lookup: the neighbourhood selects a bit of the rule byte.
module ca_rule_cell
  import wolfram_ca_engine_pkg::*;
(
  input  logic       l,
  input  logic       c,
  input  logic       r,
  input  logic [7:0] rule,
  output logic       next
);

  // Bit 7 - {l,c,r} of the rule is the same as indexing with the inverted neighbourhood.
  logic [RULE_IDX_W-1:0] idx;

  assign idx  = ~{l, c, r};
  assign next = rule[idx];

endmodule

// File: rtl/wolfram_ca_engine.sv
// Elementary cellular automaton engine: loads a seed, then evolves it for a
// latched number of generations, stopping early on a fixed point.
module wolfram_ca_engine
  import wolfram_ca_engine_pkg::*;
#(
  parameter int N_CELLS = 8,
  parameter int WRAP    = 1,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         rule,
  input  logic [N_CELLS-1:0] seed,
  input  logic               load,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_steps,
  input  logic               halt,
  output logic [N_CELLS-1:0] cells,
  output logic               busy,
  output logic               done,
  output logic               stable,
  output logic [CNT_W-1:0]   gen_count
);

  ca_state_t          state;
  logic [N_CELLS-1:0] cells_q;
  logic [N_CELLS-1:0] cells_next;
  logic [N_CELLS-1:0] left_nb;
  logic [N_CELLS-1:0] right_nb;
  logic [7:0]         rule_q;
  logic [CNT_W-1:0]   steps_q;
  logic [CNT_W-1:0]   gen_q;
  logic [CNT_W-1:0]   gen_inc;
  logic               busy_q;
  logic               done_q;
  logic               stable_q;

  // Higher index is the left neighbour; the edges either wrap or read zero.
  for (genvar i = 0; i < N_CELLS; i++) begin : g_cell
    if (i == N_CELLS - 1) begin : g_left_edge
      assign left_nb[i] = (WRAP != 0) ? cells_q[0] : 1'b0;
    end else begin : g_left_mid
      assign left_nb[i] = cells_q[i+1];
    end

    if (i == 0) begin : g_right_edge
      assign right_nb[i] = (WRAP != 0) ? cells_q[N_CELLS-1] : 1'b0;
    end else begin : g_right_mid
      assign right_nb[i] = cells_q[i-1];
    end

    ca_rule_cell u_cell (
      .l    (left_nb[i]),
      .c    (cells_q[i]),
      .r    (right_nb[i]),
      .rule (rule_q),
      .next (cells_next[i])
    );
  end

  assign gen_inc = gen_q + {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cells_q  <= '0;
      rule_q   <= '0;
      steps_q  <= '0;
      gen_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          // Load wins over start when both arrive together.
          if (load) begin
            cells_q <= seed;
          end else if (start) begin
            rule_q   <= rule;
            steps_q  <= num_steps;
            gen_q    <= '0;
            stable_q <= 1'b0;
            if (num_steps == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state  <= RUN;
              busy_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (!halt) begin
            cells_q <= cells_next;
            gen_q   <= gen_inc;
            if ((gen_inc == steps_q) || (cells_next == cells_q)) begin
              state    <= DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              stable_q <= (cells_next == cells_q);
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign cells     = cells_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign stable    = stable_q;
  assign gen_count = gen_q;

endmodule

// File: tb/tb_wolfram_ca_engine.sv
// Directed bench for wolfram_ca_engine: a wrapping and a null-boundary instance
// share the same stimulus.
module tb_wolfram_ca_engine;

  logic       clk;
  logic       rst_n;
  logic [7:0] rule;
  logic [7:0] seed;
  logic       load;
  logic       start;
  logic [7:0] num_steps;
  logic       halt;

  logic [7:0] cells_w, cells_n;
  logic       busy_w, busy_n;
  logic       done_w, done_n;
  logic       stable_w, stable_n;
  logic [7:0] gen_w, gen_n;

  int checks;
  int errors;
  int busy_cycles;

  wolfram_ca_engine #(.N_CELLS(8), .WRAP(1), .CNT_W(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rule      (rule),
    .seed      (seed),
    .load      (load),
    .start     (start),
    .num_steps (num_steps),
    .halt      (halt),
    .cells     (cells_w),
    .busy      (busy_w),
    .done      (done_w),
    .stable    (stable_w),
    .gen_count (gen_w)
  );

  wolfram_ca_engine #(.N_CELLS(8), .WRAP(0), .CNT_W(8)) u_dut_null (
    .clk       (clk),
    .rst_n     (rst_n),
    .rule      (rule),
    .seed      (seed),
    .load      (load),
    .start     (start),
    .num_steps (num_steps),
    .halt      (halt),
    .cells     (cells_n),
    .busy      (busy_n),
    .done      (done_n),
    .stable    (stable_n),
    .gen_count (gen_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (busy_w) busy_cycles++;
  endtask

  task automatic applyStimulus(input logic l, input logic [7:0] s, input logic st,
                               input logic [7:0] r, input logic [7:0] n, input logic h);
    load      = l;
    seed      = s;
    start     = st;
    rule      = r;
    num_steps = n;
    halt      = h;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    busy_cycles = 0;
    rst_n = 1'b0;
    load = 0; seed = 8'h00; start = 0; rule = 8'h00; num_steps = 8'h00; halt = 0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_cells", cells_w, 8'h00);
    checkOutput("reset_busy", busy_w, 1'b0);
    checkOutput("reset_done", done_w, 1'b0);
    checkOutput("reset_stable", stable_w, 1'b0);
    checkOutput("reset_gen", gen_w, 8'h00);
    rst_n = 1'b1;

    // Rule 0xB4 from all-zero: all ones, then all zeros.
    $display("[TB] rule B4 two steps");
    applyStimulus(1, 8'h00, 0, 8'h00, 8'd0, 0);
    applyStimulus(0, 8'h00, 1, 8'hB4, 8'd2, 0);
    checkOutput("b4_busy_start", busy_w, 1'b1);
    checkOutput("b4_gen_start", gen_w, 8'd0);
    applyStimulus(0, 8'h00, 0, 8'h00, 8'd0, 0);
    checkOutput("b4_cells_step1", cells_w, 8'hFF);
    checkOutput("b4_gen_step1", gen_w, 8'd1);
    tick();
    checkOutput("b4_cells_step2", cells_w, 8'h00);
    checkOutput("b4_done", done_w, 1'b1);
    checkOutput("b4_busy_done", busy_w, 1'b0);
    checkOutput("b4_gen_done", gen_w, 8'd2);
    checkOutput("b4_stable", stable_w, 1'b0);
    tick();
    checkOutput("b4_done_pulse_end", done_w, 1'b0);
    checkOutput("b4_gen_hold", gen_w, 8'd2);

    // Rule 0x55 copies the right neighbour; the boundary decides bit 0.
    $display("[TB] rule 55 shift, wrap vs null");
    applyStimulus(1, 8'h81, 0, 8'h00, 8'd0, 0);
    applyStimulus(0, 8'h00, 1, 8'h55, 8'd1, 0);
    applyStimulus(0, 8'h00, 0, 8'h00, 8'd0, 0);
    checkOutput("r55_wrap_cells", cells_w, 8'h03);
    checkOutput("r55_null_cells", cells_n, 8'h02);
    checkOutput("r55_done", done_w, 1'b1);
    checkOutput("r55_gen", gen_w, 8'd1);
    tick();

    // Identity rule reaches a fixed point after one generation.
    $display("[TB] rule 33 fixed point");
    applyStimulus(1, 8'h5A, 0, 8'h00, 8'd0, 0);
    applyStimulus(0, 8'h00, 1, 8'h33, 8'd10, 0);
    applyStimulus(0, 8'h00, 0, 8'h00, 8'd0, 0);
    checkOutput("r33_done", done_w, 1'b1);
    checkOutput("r33_stable", stable_w, 1'b1);
    checkOutput("r33_gen", gen_w, 8'd1);
    checkOutput("r33_cells", cells_w, 8'h5A);
    tick();
    checkOutput("r33_stable_hold", stable_w, 1'b1);

    // Invert rule with a three-cycle halt; load/start/rule changes mid-run are ignored.
    $display("[TB] rule CC with halt");
    applyStimulus(1, 8'h0F, 0, 8'h00, 8'd0, 0);
    busy_cycles = 0;
    applyStimulus(0, 8'h00, 1, 8'hCC, 8'd4, 0);
    applyStimulus(0, 8'h00, 0, 8'h00, 8'd0, 0);
    checkOutput("cc_cells_step1", cells_w, 8'hF0);
    applyStimulus(1, 8'hAA, 1, 8'h00, 8'd1, 1);
    applyStimulus(1, 8'hAA, 1, 8'h00, 8'd1, 1);
    applyStimulus(1, 8'hAA, 1, 8'h00, 8'd1, 1);
    checkOutput("cc_halt_cells", cells_w, 8'hF0);
    checkOutput("cc_halt_gen", gen_w, 8'd1);
    checkOutput("cc_halt_busy", busy_w, 1'b1);
    applyStimulus(0, 8'h00, 0, 8'h00, 8'd0, 0);
    checkOutput("cc_cells_step2", cells_w, 8'h0F);
    tick();
    checkOutput("cc_cells_step3", cells_w, 8'hF0);
    tick();
    checkOutput("cc_cells_end", cells_w, 8'h0F);
    checkOutput("cc_done", done_w, 1'b1);
    checkOutput("cc_gen", gen_w, 8'd4);
    checkOutput("cc_stable", stable_w, 1'b0);
    checkOutput("cc_busy_cycles", busy_cycles, 7);
    applyStimulus(1, 8'hFF, 0, 8'h00, 8'd0, 0);
    checkOutput("load_in_done_ignored", cells_w, 8'h0F);
    checkOutput("done_cleared", done_w, 1'b0);

    // Zero-step run goes straight to DONE without ever raising busy.
    $display("[TB] zero-step start");
    busy_cycles = 0;
    applyStimulus(0, 8'h00, 1, 8'hCC, 8'd0, 0);
    checkOutput("zero_done", done_w, 1'b1);
    checkOutput("zero_cells", cells_w, 8'h0F);
    checkOutput("zero_gen", gen_w, 8'd0);
    applyStimulus(0, 8'h00, 0, 8'h00, 8'd0, 0);
    checkOutput("zero_done_end", done_w, 1'b0);
    checkOutput("zero_busy_cycles", busy_cycles, 0);

    // Load and start together: load wins.
    $display("[TB] load and start together");
    applyStimulus(1, 8'h3C, 1, 8'hCC, 8'd20, 0);
    checkOutput("ls_cells", cells_w, 8'h3C);
    checkOutput("ls_busy", busy_w, 1'b0);

    // Asynchronous reset in the middle of a run.
    $display("[TB] reset mid-run");
    applyStimulus(0, 8'h00, 1, 8'hCC, 8'd20, 0);
    applyStimulus(0, 8'h00, 0, 8'h00, 8'd0, 0);
    checkOutput("mr_cells_step1", cells_w, 8'hC3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mr_async_cells", cells_w, 8'h00);
    checkOutput("mr_async_busy", busy_w, 1'b0);
    checkOutput("mr_async_gen", gen_w, 8'h00);
    tick();
    checkOutput("mr_no_done", done_w, 1'b0);
    rst_n = 1'b1;
    applyStimulus(1, 8'h99, 0, 8'h00, 8'd0, 0);
    checkOutput("mr_load_after_reset", cells_w, 8'h99);
    applyStimulus(0, 8'h00, 1, 8'h55, 8'd1, 0);
    checkOutput("mr_start_after_reset", busy_w, 1'b1);
    tick();
    checkOutput("mr_run_result", cells_w, 8'h33);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wolfram_ca_engine.md
WOLFRAM_CA_ENGINE -- requirements
Module: wolfram_ca_engine

Interface
REQ-001 Parameter: N_CELLS, 8, number of cells in the 1-D automaton (>=3).
REQ-002 Parameter: WRAP, 1, boundary mode; 1 = periodic wrap-around, 0 = null boundary (off-array neighbours read 0).
REQ-003 Parameter: CNT_W, 8, width of step count and generation counter.
REQ-004 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port: rule  in  8  rule byte, sampled on start.
REQ-007 Port: seed  in  N_CELLS  initial cell pattern, sampled on load.
REQ-008 Port: load  in  1  write seed into cell register.
REQ-009 Port: start  in  1  begin a run of num_steps generations.
REQ-010 Port: num_steps  in  CNT_W  generations to compute, sampled on start.
REQ-011 Port: halt  in  1  pause evolution while high during RUN.
REQ-012 Port: cells  out  N_CELLS  current cell register.
REQ-013 Port: busy  out  1  high in RUN.
REQ-014 Port: done  out  1  one-cycle pulse when a run ends.
REQ-015 Port: stable  out  1  run ended on a fixed point.
REQ-016 Port: gen_count  out  CNT_W  generations computed in the current/last run.

Function
REQ-017 Cell i SHALL have left neighbour cells[i+1] and right neighbour cells[i-1]; cells[N_CELLS-1] is leftmost.
REQ-018 Next value of cell i SHALL be rule[7 - {left, centre, right}], the 3-bit index formed with left as MSB.
REQ-019 At the edges, WRAP=1 SHALL use cells[0] as left of cells[N_CELLS-1] and cells[N_CELLS-1] as right of cells[0]; WRAP=0 SHALL use 0 for both.
REQ-020 FSM states: IDLE, RUN, DONE; DONE SHALL last exactly one cycle and return to IDLE.
REQ-021 IDLE + start: latch rule and num_steps, clear gen_count and stable, enter RUN; if num_steps=0, enter DONE instead with cells unchanged.
REQ-022 RUN, halt low: one generation per cycle, all cells updated simultaneously, gen_count incremented.
REQ-023 RUN, halt high: cells and gen_count SHALL hold.
REQ-024 RUN SHALL exit to DONE in the cycle the generation count reaches the latched num_steps.
REQ-025 RUN SHALL also exit to DONE when a computed generation equals the current cells; that generation still counts, and stable SHALL be set.
REQ-026 done SHALL be asserted only in the DONE state; busy SHALL be asserted only in RUN.
REQ-027 load SHALL be honoured only in IDLE and SHALL be ignored in RUN and DONE.
REQ-028 If load and start are both high in IDLE, load SHALL take effect and start SHALL be ignored.
REQ-029 start, rule, and num_steps changes during RUN SHALL be ignored; the latched values govern the run.
REQ-030 stable and gen_count SHALL hold after DONE until the next accepted start.
REQ-031 gen_count SHALL never wrap, because the run ends when it reaches num_steps.

Reset
REQ-032 Assertion of rst_n low SHALL immediately force IDLE and clear cells, gen_count, busy, done, stable, and the latched rule and step count, including mid-run.
REQ-033 After deassertion, the block SHALL accept load or start on the first rising edge.

Structure
REQ-034 A shared package SHALL hold the FSM state enum and the rule-index width constant (3).
REQ-035 The per-cell rule lookup SHALL be one sub-module, ca_rule_cell (inputs l, c, r, rule; output next), instantiated N_CELLS times by generate.

Verification
REQ-036 N=8, WRAP=1, rule 0xB4, seed 0x00, num_steps 2 -> cells 0xFF after step 1, 0x00 after step 2; done pulse; gen_count 2; stable 0.
REQ-037 Rule 0x55 (out=right), seed 0x81, 1 step: WRAP=1 -> 0x03; WRAP=0 -> 0x02.
REQ-038 Rule 0x33 (identity), seed 0x5A, num_steps 10 -> done after 1 generation; stable 1; gen_count 1; cells 0x5A.
REQ-039 Rule 0xCC (invert), seed 0x0F, num_steps 4, halt high for 3 cycles mid-run -> cells 0x0F at end; busy extends by 3 cycles; gen_count 4.
REQ-040 num_steps 0 start -> done pulse the next cycle, cells unchanged, busy never high; load during RUN -> ignored.
REQ-041 rst_n pulsed low mid-run -> cells 0x00, IDLE, busy 0 asynchronously; no done pulse.
